// File: rtl/fifo_pkt_pkg.sv
// Shared types for the FIFO packet reader: FSM states and output-buffer entries.
// The entry data width is the stream width; the reader's DATA_WIDTH defaults to it.
package fifo_pkt_pkg;

    localparam int unsigned PKT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKT_DATA_WIDTH-1:0] data;
        logic                      last;
    } buf_entry_t;

endpackage

// File: rtl/pkt_out_buf.sv
// Two-entry FIFO-ordered output buffer presenting a valid/ready stream.
// The head entry drives the stream and only changes on a pop or a push into an empty buffer.
module pkt_out_buf
    import fifo_pkt_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [PKT_DATA_WIDTH-1:0] data,
    input  logic                      last,
    input  logic                      ready,
    output logic [1:0]                cnt,
    output logic [PKT_DATA_WIDTH-1:0] tdata,
    output logic                      tvalid,
    output logic                      tlast
);

    buf_entry_t head;
    buf_entry_t tail;
    buf_entry_t in_entry;
    logic       pop;

    assign in_entry = '{data: data, last: last};
    assign tvalid   = (cnt != 2'd0);
    assign pop      = tvalid && ready;
    assign tdata    = head.data;
    assign tlast    = head.last;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt  <= 2'd0;
            // NOTE: storage is reset only because tdata_o/tlast_o must read 0 out of reset.
            head <= '0;
            tail <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_entry;
                    else             tail <= in_entry;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= in_entry;
                    end else begin
                        head <= tail;
                        tail <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from a show-ahead FIFO and frames them as a stream
// with tlast; bad lengths are flagged and their payload dropped to keep alignment.
module fifo_pkt_reader
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = PKT_DATA_WIDTH,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_LEN    = 2**LEN_WIDTH - 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_rd_o,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  tlast_o,
    output logic                  pkt_done_o,
    output logic                  len_err_o,
    output logic                  busy_o
);

    localparam logic [LEN_WIDTH:0] MAX_LEN_EXT = (LEN_WIDTH+1)'(MAX_LEN);

    state_t               state;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic [1:0]           buf_cnt;
    logic                 hdr_too_long;
    logic                 last_word;
    logic                 buf_push;

    assign hdr_len      = fifo_rd_data_i[LEN_WIDTH-1:0];
    assign hdr_too_long = ({1'b0, hdr_len} > MAX_LEN_EXT);
    assign last_word    = (cnt == LEN_WIDTH'(1));
    assign busy_o       = (state != S_HDR) || (buf_cnt != 2'd0);

    // Pop and its status pulses come from registered state, the FIFO flags and
    // the registered buffer occupancy only, so tready_i never reaches fifo_rd_o.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        fifo_rd_o  = 1'b0;
        buf_push   = 1'b0;
        pkt_done_o = 1'b0;
        len_err_o  = 1'b0;
        if (rst_i && !fifo_empty_i) begin
            unique case (state)
                S_HDR: begin
                    fifo_rd_o = 1'b1;
                    len_err_o = (hdr_len == '0) || hdr_too_long;
                end
                S_DATA: begin
                    if (buf_cnt < 2'd2) begin
                        fifo_rd_o  = 1'b1;
                        buf_push   = 1'b1;
                        pkt_done_o = last_word;
                    end
                end
                S_DROP: fifo_rd_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_HDR;
            cnt   <= '0;
        end else if (fifo_rd_o) begin
            unique case (state)
                S_HDR: begin
                    if (hdr_len != '0) begin
                        cnt   <= hdr_len;
                        state <= hdr_too_long ? S_DROP : S_DATA;
                    end
                end
                S_DATA, S_DROP: begin
                    cnt <= cnt - LEN_WIDTH'(1);
                    if (last_word) state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end

    pkt_out_buf u_out_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (buf_push),
        .data   (fifo_rd_data_i),
        .last   (last_word),
        .ready  (tready_i),
        .cnt    (buf_cnt),
        .tdata  (tdata_o),
        .tvalid (tvalid_o),
        .tlast  (tlast_o)
    );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader (MAX_LEN = 4): directed cases then random
// traffic, all checked against a packet-level reference model kept in the bench.
module tb_fifo_pkt_reader;

    localparam int MAX_LEN = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       fifo_empty_i;
    logic [7:0] fifo_rd_data_i;
    logic       fifo_rd_o;
    logic [7:0] tdata_o;
    logic       tvalid_o;
    logic       tready_i;
    logic       tlast_o;
    logic       pkt_done_o;
    logic       len_err_o;
    logic       busy_o;

    fifo_pkt_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8), .MAX_LEN(MAX_LEN)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_rd_o      (fifo_rd_o),
        .tdata_o        (tdata_o),
        .tvalid_o       (tvalid_o),
        .tready_i       (tready_i),
        .tlast_o        (tlast_o),
        .pkt_done_o     (pkt_done_o),
        .len_err_o      (len_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, words still to come for the current packet,
    // and payload words popped but not yet accepted on the stream.
    logic [7:0] fq[$];
    logic [7:0] wq[$];
    beat_t      exp_beats[$];
    int         beat_cyc[$];
    int         words_left = 0;
    bit         dropping   = 0;
    bit         rand_mode  = 0;
    int         cyc = 0, n_pops = 0, n_beats = 0, n_done = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        fifo_empty_i   = (fq.size() == 0);
        fifo_rd_data_i = (fq.size() != 0) ? fq[0] : 8'hEE;
    endtask

    task automatic put(input logic [7:0] w);
        fq.push_back(w);
        apply_inputs();
    endtask

    // One clock cycle: check settled outputs at the falling edge, then update the
    // model and drive new inputs just after the rising edge.
    task automatic step();
        logic       pop, beat;
        logic [7:0] w;
        bit         exp_rd;
        int         hdr;
        @(negedge clk_i);
        cyc++;
        pop  = fifo_rd_o;
        beat = tvalid_o && tready_i;
        hdr  = (fq.size() != 0) ? int'(fq[0]) : 0;
        exp_rd = (fq.size() != 0) && (words_left == 0 || dropping || exp_beats.size() < 2);
        check("fifo_rd", pop, exp_rd);
        check("pkt_done", pkt_done_o, pop && words_left == 1 && !dropping);
        check("len_err", len_err_o, pop && words_left == 0 && (hdr == 0 || hdr > MAX_LEN));
        check("tvalid", tvalid_o, exp_beats.size() != 0);
        check("busy", busy_o, words_left != 0 || exp_beats.size() != 0);
        if (exp_beats.size() != 0) begin
            check("tdata", tdata_o, exp_beats[0].data);
            check("tlast", tlast_o, exp_beats[0].last);
        end
        if (pkt_done_o) n_done++;
        if (len_err_o)  n_err++;
        @(posedge clk_i);
        #1;
        if (beat && exp_beats.size() != 0) begin
            void'(exp_beats.pop_front());
            beat_cyc.push_back(cyc);
            n_beats++;
        end
        if (pop && fq.size() != 0) begin
            w = fq.pop_front();
            n_pops++;
            if (words_left == 0) begin
                if (w != 8'h00) begin
                    words_left = int'(w);
                    dropping   = (int'(w) > MAX_LEN);
                end
            end else begin
                words_left--;
                if (!dropping) exp_beats.push_back('{data: w, last: (words_left == 0)});
            end
        end
        if (rand_mode) begin
            if (wq.size() != 0 && $urandom_range(99) < 70) fq.push_back(wq.pop_front());
            tready_i = 1'($urandom_range(1));
        end
        apply_inputs();
    endtask

    initial begin
        int c0, b0, d0, e0, p0, exp_b, exp_d, exp_e, len;
        bit idle, seen;

        // Reset with a word waiting in the FIFO: nothing may be popped.
        rst_i = 1'b0;
        tready_i = 1'b0;
        put(8'h01);
        put(8'h55);
        @(posedge clk_i);
        #1;
        check("rst_rd", fifo_rd_o, 0);
        check("rst_tvalid", tvalid_o, 0);
        check("rst_tdata", tdata_o, 0);
        check("rst_tlast", tlast_o, 0);
        check("rst_done", pkt_done_o, 0);
        check("rst_err", len_err_o, 0);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b1;
        tready_i = 1'b1;
        repeat (6) step();

        // Header 3: three consecutive beats, tlast only on the third.
        c0 = cyc + 1; b0 = n_beats; d0 = n_done;
        put(8'h03); put(8'hA1); put(8'hA2); put(8'hA3);
        repeat (8) step();
        check("t1_beats", n_beats - b0, 3);
        check("t1_first_cyc", beat_cyc[b0], c0 + 2);
        check("t1_last_cyc", beat_cyc[b0+2], c0 + 4);
        check("t1_done", n_done - d0, 1);

        // Back-to-back headers 1 and 2: one idle cycle for the second header.
        c0 = cyc + 1; b0 = n_beats;
        put(8'h01); put(8'h11); put(8'h02); put(8'h21); put(8'h22);
        repeat (9) step();
        check("t2_beats", n_beats - b0, 3);
        check("t2_beat0", beat_cyc[b0], c0 + 2);
        check("t2_beat1", beat_cyc[b0+1], c0 + 4);
        check("t2_beat2", beat_cyc[b0+2], c0 + 5);

        // Zero-length header, then a good one-word packet.
        b0 = n_beats; e0 = n_err;
        put(8'h00); put(8'h01); put(8'hB1);
        repeat (6) step();
        check("t3_err", n_err - e0, 1);
        check("t3_beats", n_beats - b0, 1);

        // Over-length header: 7 pops dropped, then C1.
        b0 = n_beats; e0 = n_err; p0 = n_pops; d0 = n_done;
        put(8'h06);
        for (int i = 0; i < 6; i++) put(8'h60 + 8'(i));
        put(8'h01); put(8'hC1);
        repeat (14) step();
        check("t4_err", n_err - e0, 1);
        check("t4_pops", n_pops - p0, 9);
        check("t4_beats", n_beats - b0, 1);
        check("t4_done", n_done - d0, 1);

        // Backpressure from the first beat for 5 cycles: only 2 payload words popped.
        tready_i = 1'b0;
        b0 = n_beats; p0 = n_pops; d0 = n_done;
        put(8'h04); put(8'hD1); put(8'hD2); put(8'hD3); put(8'hD4);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = tvalid_o;
        end
        check("t5_first_beat_seen", seen, 1);
        repeat (5) step();
        check("t5_pops_stalled", n_pops - p0, 3);
        check("t5_head_held", tdata_o, 8'hD1);
        tready_i = 1'b1;
        repeat (8) step();
        check("t5_beats", n_beats - b0, 4);
        check("t5_done", n_done - d0, 1);

        // FIFO runs dry mid-packet, then reset abandons it; next word is a header.
        put(8'h04); put(8'hE1); put(8'hE2);
        repeat (8) step();
        check("t6_stalled_busy", busy_o, 1);
        put(8'h01); put(8'hF1);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t6_rst_rd", fifo_rd_o, 0);
        @(posedge clk_i);
        #1;
        check("t6_tvalid", tvalid_o, 0);
        check("t6_busy", busy_o, 0);
        rst_i = 1'b1;
        words_left = 0;
        dropping = 0;
        exp_beats.delete();
        b0 = n_beats; e0 = n_err; d0 = n_done;
        repeat (6) step();
        check("t6_beats", n_beats - b0, 1);
        check("t6_err", n_err - e0, 0);
        check("t6_done", n_done - d0, 1);

        // Random packets, random FIFO fill gaps and random ready.
        b0 = n_beats; e0 = n_err; d0 = n_done;
        exp_b = 0; exp_d = 0; exp_e = 0;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(0, 7);
            wq.push_back(8'(len));
            for (int i = 0; i < len; i++) wq.push_back(8'($urandom_range(255)));
            if (len == 0 || len > MAX_LEN) exp_e++;
            else begin exp_b += len; exp_d++; end
        end
        rand_mode = 1;
        idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            step();
            idle = (wq.size() == 0 && fq.size() == 0 && words_left == 0 && exp_beats.size() == 0);
        end
        rand_mode = 0;
        check("rand_drained", idle, 1);
        check("rand_beats", n_beats - b0, exp_b);
        check("rand_done", n_done - d0, exp_d);
        check("rand_err", n_err - e0, exp_e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
